// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter blocks: sequencer state encoding and
// the accumulator sizing rule.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    MAC_S    = 2'd1,
    ROUND_S  = 2'd2,
    OUTPUT_S = 2'd3
  } firStateE;

  // Worst-case sum of numTaps full-scale products never overflows this width.
  function automatic int unsigned accWidth(input int unsigned dataWidth,
                                           input int unsigned coeffWidth,
                                           input int unsigned numTaps);
    return dataWidth + coeffWidth + $clog2(numTaps);
  endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Sample and coefficient port bundle of the FIR sequencer. The master side is
// the client that supplies samples and coefficients; the slave side is the filter.
interface fir_sequencer_if #(
  parameter int unsigned DataWidth  = 12,
  parameter int unsigned CoeffWidth = 12,
  parameter int unsigned NumTaps    = 16
);
  localparam int unsigned AddrWidth = $clog2(NumTaps);

  logic signed [DataWidth-1:0]  sampleIn;
  logic                         sampleInValid;
  logic                         coeffWrEn;
  logic [AddrWidth-1:0]         coeffWrAddr;
  logic signed [CoeffWidth-1:0] coeffWrData;
  logic                         coeffWrReady;
  logic                         clearOverrun;
  logic signed [DataWidth-1:0]  sampleOut;
  logic                         sampleOutValid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output sampleIn, sampleInValid, coeffWrEn, coeffWrAddr, coeffWrData, clearOverrun,
    input  coeffWrReady, sampleOut, sampleOutValid, busy, overrun
  );

  modport slave (
    input  sampleIn, sampleInValid, coeffWrEn, coeffWrAddr, coeffWrData, clearOverrun,
    output coeffWrReady, sampleOut, sampleOutValid, busy, overrun
  );

endinterface

// File: rtl/fir_mac.sv
// Signed multiply-accumulate datapath: one product per enabled cycle into a
// full-precision accumulator with synchronous clear.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DataWidth  = 12,
  parameter int unsigned CoeffWidth = 12,
  parameter int unsigned NumTaps    = 16,
  parameter int unsigned AccWidth   = accWidth(DataWidth, CoeffWidth, NumTaps)
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         accClear,
  input  logic                         accEn,
  input  logic signed [DataWidth-1:0]  sample,
  input  logic signed [CoeffWidth-1:0] coeff,
  output logic signed [AccWidth-1:0]   acc
);

  localparam int unsigned ProdWidth = DataWidth + CoeffWidth;

  logic signed [ProdWidth-1:0] product;
  logic signed [AccWidth-1:0]  productExt;

  assign product    = ProdWidth'(sample) * ProdWidth'(coeff);
  assign productExt = AccWidth'(product);

  // Clear has priority so a new computation always starts from zero.
  always_ff @(posedge clk or negedge resetN) begin : accReg
    if (!resetN) begin
      acc <= '0;
    end else if (accClear) begin
      acc <= '0;
    end else if (accEn) begin
      acc <= acc + productExt;
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// Time-multiplexed FIR filter: one MAC per tap per input sample, with ring
// buffer history, writable coefficients, saturation and overrun flagging.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DataWidth  = 12,
  parameter int unsigned CoeffWidth = 12,
  parameter int unsigned NumTaps    = 16
) (
  input  logic            clk,
  input  logic            resetN,
  fir_sequencer_if.slave  bus
);

  localparam int unsigned AddrWidth = $clog2(NumTaps);
  localparam int unsigned AccWidth  = accWidth(DataWidth, CoeffWidth, NumTaps);
  localparam int unsigned FracBits  = CoeffWidth - 1;
  localparam logic signed [AccWidth-1:0] MaxOut = AccWidth'((1 << (DataWidth - 1)) - 1);
  localparam logic signed [AccWidth-1:0] MinOut = AccWidth'(-(1 << (DataWidth - 1)));
  localparam logic [AddrWidth-1:0]       LastStep = AddrWidth'(NumTaps - 1);

  firStateE state;
  firStateE nextState;

  logic                         prevValid;
  logic                         inEdge;
  logic                         accept;
  logic                         dropSample;
  logic                         coeffWrite;
  logic                         accClear;
  logic                         accEn;
  logic [AddrWidth-1:0]         wrPtr;
  logic [AddrWidth-1:0]         macStep;
  logic [AddrWidth-1:0]         rdIdx;
  logic signed [DataWidth-1:0]  xBuf [NumTaps];
  logic signed [CoeffWidth-1:0] hBuf [NumTaps];
  logic signed [AccWidth-1:0]   acc;
  logic signed [AccWidth-1:0]   accShift;
  logic signed [DataWidth-1:0]  roundVal;

  // A level held high counts once: only the low-to-high transition is a request.
  assign inEdge     = bus.sampleInValid & ~prevValid;
  assign accept     = inEdge & (state == IDLE_S);
  assign dropSample = inEdge & (state != IDLE_S);
  assign coeffWrite = bus.coeffWrEn & bus.coeffWrReady;

  // wrPtr already points past the newest sample, so newest-k is wrPtr-1-k.
  assign rdIdx = wrPtr - AddrWidth'(1) - macStep;

  always_ff @(posedge clk or negedge resetN) begin : stateReg
    if (!resetN) begin
      state <= IDLE_S;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin : nextStateLogic
    nextState = state;
    accClear  = 1'b0;
    accEn     = 1'b0;
    unique case (state)
      IDLE_S: begin
        if (inEdge) begin
          nextState = MAC_S;
          accClear  = 1'b1;
        end
      end
      MAC_S: begin
        accEn = 1'b1;
        if (macStep == LastStep) begin
          nextState = ROUND_S;
        end
      end
      ROUND_S:  nextState = OUTPUT_S;
      OUTPUT_S: nextState = IDLE_S;
      default:  nextState = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin : edgeReg
    if (!resetN) begin
      prevValid <= 1'b0;
    end else begin
      prevValid <= bus.sampleInValid;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin : stepCounter
    if (!resetN) begin
      macStep <= '0;
    end else if (accClear) begin
      macStep <= '0;
    end else if (accEn) begin
      macStep <= macStep + AddrWidth'(1);
    end
  end

  // Sample history; a dropped sample leaves both buffer and pointer untouched.
  always_ff @(posedge clk or negedge resetN) begin : ringBuffer
    if (!resetN) begin
      wrPtr <= '0;
      for (int i = 0; i < int'(NumTaps); i++) begin
        xBuf[i] <= '0;
      end
    end else if (accept) begin
      xBuf[wrPtr] <= bus.sampleIn;
      wrPtr       <= wrPtr + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin : coeffStore
    if (!resetN) begin
      for (int i = 0; i < int'(NumTaps); i++) begin
        hBuf[i] <= '0;
      end
    end else if (coeffWrite) begin
      hBuf[bus.coeffWrAddr] <= bus.coeffWrData;
    end
  end

  fir_mac #(
    .DataWidth  (DataWidth),
    .CoeffWidth (CoeffWidth),
    .NumTaps    (NumTaps),
    .AccWidth   (AccWidth)
  ) uMac (
    .clk      (clk),
    .resetN   (resetN),
    .accClear (accClear),
    .accEn    (accEn),
    .sample   (xBuf[rdIdx]),
    .coeff    (hBuf[macStep]),
    .acc      (acc)
  );

  // Drop the Q1.(CoeffWidth-1) fraction (floor) and clamp to the output range.
  assign accShift = acc >>> FracBits;

  always_comb begin : saturate
    roundVal = DataWidth'(accShift);
    if (accShift > MaxOut) begin
      roundVal = DataWidth'(MaxOut);
    end else if (accShift < MinOut) begin
      roundVal = DataWidth'(MinOut);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin : outRegs
    if (!resetN) begin
      bus.sampleOut      <= '0;
      bus.sampleOutValid <= 1'b0;
      bus.busy           <= 1'b0;
      bus.coeffWrReady   <= 1'b1;
      bus.overrun        <= 1'b0;
    end else begin
      bus.sampleOutValid <= (nextState == OUTPUT_S);
      bus.busy           <= (nextState != IDLE_S);
      bus.coeffWrReady   <= (nextState == IDLE_S);
      if (state == ROUND_S) begin
        bus.sampleOut <= roundVal;
      end
      if (dropSample) begin
        bus.overrun <= 1'b1;
      end else if (bus.clearOverrun) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: a sample-level reference filter queues
// expected outputs; a monitor checks outputs, timing and status flags.
module tb_fir_sequencer;

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 12;
  localparam int unsigned NT = 16;
  localparam int unsigned AW = $clog2(NT);

  typedef struct {
    int value;
    int cyc;
  } expT;

  logic clk;
  logic resetN;

  fir_sequencer_if #(.DataWidth(DW), .CoeffWidth(CW), .NumTaps(NT)) bus ();

  fir_sequencer #(.DataWidth(DW), .CoeffWidth(CW), .NumTaps(NT)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  expT expQ[$];
  expT monExp;
  int  holdExp = 0;

  // Reference state: history newest-first, coefficients, job timing, flags.
  int  hist[NT];
  int  coef[NT];
  bit  prevVin = 1'b0;
  bit  ovrModel = 1'b0;
  bit  jobActive = 1'b0;
  int  lastAcc = 0;

  // A computation occupies the NT+2 cycles following its accepting cycle.
  function automatic bit busyAt(input int c);
    return jobActive && (c >= lastAcc + 1) && (c <= lastAcc + int'(NT) + 2);
  endfunction

  function automatic int refFilter();
    longint sum = 0;
    for (int k = 0; k < int'(NT); k++) begin
      sum += longint'(hist[k]) * longint'(coef[k]);
    end
    sum = sum >>> (CW - 1);
    if (sum > longint'((1 << (DW - 1)) - 1)) sum = longint'((1 << (DW - 1)) - 1);
    if (sum < -longint'(1 << (DW - 1)))      sum = -longint'(1 << (DW - 1));
    return int'(sum);
  endfunction

  task automatic clearModel();
    for (int k = 0; k < int'(NT); k++) begin
      hist[k] = 0;
      coef[k] = 0;
    end
    expQ.delete();
    prevVin   = 1'b0;
    ovrModel  = 1'b0;
    jobActive = 1'b0;
  endtask

  // Present one cycle of inputs, update the reference, advance to next negedge.
  task automatic drive(input bit vin, input int din, input bit wen,
                       input int wa, input int wd, input bit clr);
    bit busyNow;
    bit rise;
    bus.sampleInValid = vin;
    bus.sampleIn      = DW'(din);
    bus.coeffWrEn     = wen;
    bus.coeffWrAddr   = AW'(wa);
    bus.coeffWrData   = CW'(wd);
    bus.clearOverrun  = clr;
    busyNow = busyAt(cyc);
    rise    = vin && !prevVin;
    prevVin = vin;
    if (wen && !busyNow) coef[wa] = wd;
    if (rise && busyNow) ovrModel = 1'b1;
    else if (clr)        ovrModel = 1'b0;
    if (rise && !busyNow) begin
      for (int k = int'(NT) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
      expQ.push_back('{value: refFilter(), cyc: cyc + int'(NT) + 2});
      lastAcc   = cyc;
      jobActive = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic doReset(input int n);
    resetN = 1'b0;
    bus.sampleInValid = 1'b0;
    bus.sampleIn      = '0;
    bus.coeffWrEn     = 1'b0;
    bus.coeffWrAddr   = '0;
    bus.coeffWrData   = '0;
    bus.clearOverrun  = 1'b0;
    clearModel();
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    resetN = 1'b1;
  endtask

  // Monitor: sample registered outputs 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (!resetN) begin
      holdExp = 0;
      checks++;
      if (int'(bus.sampleOut) != 0 || bus.sampleOutValid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.coeffWrReady !== 1'b1 || bus.overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d out=%0d valid=%b busy=%b ready=%b ovr=%b required 0 0 0 1 0",
                 cyc, int'(bus.sampleOut), bus.sampleOutValid, bus.busy, bus.coeffWrReady, bus.overrun);
      end
    end else begin
      checks++;
      if (bus.busy !== busyAt(cyc) || bus.coeffWrReady !== !busyAt(cyc)) begin
        errors++;
        $display("FAIL busy_ready cyc=%0d busy=%b ready=%b required busy=%b", cyc,
                 bus.busy, bus.coeffWrReady, busyAt(cyc));
      end
      checks++;
      if (bus.overrun !== ovrModel) begin
        errors++;
        $display("FAIL overrun cyc=%0d got=%b required=%b", cyc, bus.overrun, ovrModel);
      end
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output cyc=%0d required value %0d at cyc %0d",
                 cyc, expQ[0].value, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      checks++;
      if (bus.sampleOutValid === 1'b1) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got=%0d required no pulse", cyc, int'(bus.sampleOut));
        end else begin
          monExp = expQ.pop_front();
          if (int'(bus.sampleOut) != monExp.value || cyc != monExp.cyc) begin
            errors++;
            $display("FAIL output cyc=%0d got=%0d required %0d at cyc %0d",
                     cyc, int'(bus.sampleOut), monExp.value, monExp.cyc);
          end
          holdExp = monExp.value;
        end
      end else if (int'(bus.sampleOut) != holdExp || $isunknown(bus.sampleOutValid)) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%0d valid=%b required %0d valid=0",
                 cyc, int'(bus.sampleOut), bus.sampleOutValid, holdExp);
      end
    end
  end

  initial begin
    doReset(3);

    // Impulse through h[0]=2047, h[1]=1024: 2046 then 1023.
    drive(1'b0, 0, 1'b1, 0, 2047, 1'b0);
    drive(1'b0, 0, 1'b1, 1, 1024, 1'b0);
    drive(1'b1, 2047, 1'b0, 0, 0, 1'b0);
    idle(20);
    drive(1'b1, 0, 1'b0, 0, 0, 1'b0);
    idle(20);

    // Level held for 5 cycles yields a single acceptance.
    repeat (5) drive(1'b1, 300, 1'b0, 0, 0, 1'b0);
    idle(20);

    // Overrun: second edge 4 cycles later, then clear, then set-vs-clear.
    drive(1'b1, 500, 1'b0, 0, 0, 1'b0);
    idle(3);
    drive(1'b1, -700, 1'b0, 0, 0, 1'b0);
    idle(20);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
    idle(2);
    drive(1'b1, 100, 1'b0, 0, 0, 1'b0);
    idle(3);
    drive(1'b1, -100, 1'b0, 0, 0, 1'b1);
    idle(20);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);

    // Coefficient write while computing must be ignored.
    drive(1'b1, 800, 1'b0, 0, 0, 1'b0);
    idle(2);
    drive(1'b0, 0, 1'b1, 3, 100, 1'b0);
    idle(20);

    // Saturation, positive then negative full scale.
    for (int k = 0; k < int'(NT); k++) drive(1'b0, 0, 1'b1, k, 2047, 1'b0);
    repeat (NT) begin
      drive(1'b1, 2047, 1'b0, 0, 0, 1'b0);
      idle(19);
    end
    repeat (NT) begin
      drive(1'b1, -2048, 1'b0, 0, 0, 1'b0);
      idle(19);
    end

    // Randomized traffic with overlapping requests, writes and clears.
    for (int it = 0; it < 60; it++) begin
      int hold;
      int gap;
      int d;
      hold = int'($urandom_range(1, 3));
      gap  = int'($urandom_range(1, 24));
      d    = int'($urandom_range(0, 4095)) - 2048;
      repeat (hold) drive(1'b1, d, ($urandom_range(0, 3) == 0), int'($urandom_range(0, NT - 1)),
                          int'($urandom_range(0, 4095)) - 2048, 1'b0);
      repeat (gap) drive(1'b0, 0, ($urandom_range(0, 3) == 0), int'($urandom_range(0, NT - 1)),
                         int'($urandom_range(0, 4095)) - 2048, ($urandom_range(0, 7) == 0));
    end
    idle(22);

    // Reset at MAC step 8 aborts the job; afterwards everything is zero.
    drive(1'b1, 1000, 1'b0, 0, 0, 1'b0);
    idle(8);
    doReset(2);
    idle(22);
    drive(1'b1, 2047, 1'b0, 0, 0, 1'b0);
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameter DataWidth, 12, sample width in bits, signed two's complement.
REQ-002 Parameter CoeffWidth, 12, coefficient width in bits, signed Q1.(CoeffWidth-1).
REQ-003 Parameter NumTaps, 16, filter length; a power of two, at least 2.
REQ-004 clk  input  1  single system clock, all state on the rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 sampleIn  input  DataWidth  signed input sample (ADC side).
REQ-007 sampleInValid  input  1  sample qualifier; may be high for more than one cycle.
REQ-008 coeffWrEn  input  1  coefficient write strobe.
REQ-009 coeffWrAddr  input  $clog2(NumTaps)  tap index k.
REQ-010 coeffWrData  input  CoeffWidth  signed coefficient h[k].
REQ-011 coeffWrReady  output  1  high when a coefficient write is accepted; equals !busy.
REQ-012 clearOverrun  input  1  clears the overrun flag.
REQ-013 sampleOut  output  DataWidth  signed filtered sample (DAC side).
REQ-014 sampleOutValid  output  1  one-cycle pulse qualifying sampleOut.
REQ-015 busy  output  1  high in every state except IDLE_S.
REQ-016 overrun  output  1  sticky flag for a dropped input sample.

Function
REQ-017 An input sample is accepted only on the rising edge of sampleInValid (registered edge detect); a level held high yields one acceptance.
REQ-018 State machine: IDLE_S -> MAC_S on acceptance; MAC_S for exactly NumTaps cycles; MAC_S -> ROUND_S -> OUTPUT_S -> IDLE_S, one cycle each.
REQ-019 On acceptance, the block writes sampleIn to ring buffer x[wrPtr], and wrPtr advances by 1 modulo NumTaps, wrapping naturally.
REQ-020 In MAC_S step k (k=0..NumTaps-1), acc += x[newest-k] * h[k], with buffer index modulo NumTaps; acc is cleared on entry to MAC_S.
REQ-021 acc width is DataWidth+CoeffWidth+$clog2(NumTaps); no overflow is possible inside acc.
REQ-022 ROUND_S computes acc >>> (CoeffWidth-1) (arithmetic, truncating) and saturates to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-023 In OUTPUT_S, sampleOut is registered and sampleOutValid is high for exactly that cycle; sampleOut holds its value until the next OUTPUT_S.
REQ-024 Latency: sampleOutValid is high NumTaps+2 clock cycles after the first cycle in which the sampleInValid rising edge is registered.
REQ-025 An acceptance edge while busy=1 drops the sample, leaves the buffer and wrPtr unchanged, and sets overrun.
REQ-026 overrun clears on clearOverrun; if set and clear occur in the same cycle, set wins.
REQ-027 A coefficient write is applied when coeffWrEn=1 and coeffWrReady=1; a write with coeffWrReady=0 is ignored with no side effect.
REQ-028 An acceptance edge and a coefficient write in the same IDLE_S cycle both take effect; the new coefficient is used in that computation.

Reset
REQ-029 resetN low immediately forces IDLE_S and clears the following to zero: sampleOut, sampleOutValid, overrun, busy, wrPtr, acc, the edge-detect register, all x[] and all h[]; coeffWrReady becomes 1.
REQ-030 Reset asserted during MAC_S, ROUND_S or OUTPUT_S aborts the computation, and no sampleOutValid pulse follows reset release.

Structure
REQ-031 Package fir_pkg holds the state enum (IDLE_S, MAC_S, ROUND_S, OUTPUT_S) and an accumulator-width function shared with other filter blocks.
REQ-032 A single sub-module fir_mac holds the signed multiplier, the accumulator register and its clear/enable control; the ring buffer, coefficient store and FSM stay in fir_sequencer.

Verification (defaults DataWidth=12, CoeffWidth=12, NumTaps=16)
REQ-033 Impulse: h[0]=2047 and h[1]=1024 (others 0); one sample 2047, then a sample 0 -> first output 2046, second output 1023.
REQ-034 Saturation: all h=2047 and 16 samples of 2047 -> final sampleOut=2047; repeat with -2048 samples -> -2048.
REQ-035 Latency/hold: sampleInValid held high for 5 cycles -> exactly one sampleOutValid, 18 cycles after the edge; busy falls the cycle after the pulse.
REQ-036 Overrun: second sampleInValid edge 4 cycles after the first -> one output only, overrun=1; clearOverrun pulse -> overrun=0; clearOverrun coincident with a new overrun -> overrun stays 1.
REQ-037 Coefficient write during MAC_S to h[3]=100 -> coeffWrReady=0, h[3] unchanged, and the output matches the model without the write.
REQ-038 Reset at MAC step 8 -> outputs 0, no sampleOutValid, and the next impulse produces a response using an all-zero history and all-zero coefficients (output 0).
